// File: rtl/pipe_stage_chain_if.sv
// Handshake and observation bundle for pipe_stage_chain: fetch-side payload,
// hazard controls, per-stage visibility, write-back output and counters.
interface pipe_stage_chain_if #(
  parameter int DW     = 32,
  parameter int STAGES = 4
);
  logic                   in_valid;
  logic [DW-1:0]          in_data;
  logic                   in_ready;
  logic [STAGES-1:0]      stall_req;
  logic                   flush;
  logic [STAGES-1:0]      stage_valid;
  logic [STAGES*DW-1:0]   stage_data;
  logic                   out_valid;
  logic [DW-1:0]          out_data;
  logic [31:0]            stall_cnt;
  logic [31:0]            flush_cnt;
  logic [31:0]            retire_cnt;

  modport master (
    output in_valid, in_data, stall_req, flush,
    input  in_ready, stage_valid, stage_data, out_valid, out_data,
           stall_cnt, flush_cnt, retire_cnt
  );

  modport slave (
    input  in_valid, in_data, stall_req, flush,
    output in_ready, stage_valid, stage_data, out_valid, out_data,
           stall_cnt, flush_cnt, retire_cnt
  );
endinterface

// File: rtl/pipe_stage_chain.sv
// Parametrised IF/ID..MEM/WB register chain with stall/bubble and front-end flush.
// Optional performance counters are built only when PIPE_PERF_CNT_EN is defined.
module pipe_stage_chain #(
  parameter int DW          = 32,
  parameter int STAGES      = 4,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  pipe_stage_chain_if.slave bus
);

  logic [STAGES-1:0] valid_q;
  logic [DW-1:0]     data_q [STAGES];
  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] bubble;

  assign bus.in_ready = ~|bus.stall_req & ~bus.flush;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam bit FLUSHABLE = (k < FLUSH_DEPTH);

    logic          valid_r;
    logic [DW-1:0] data_r;
    logic          next_valid;
    logic [DW-1:0] next_data;

    // A register holds whenever it sits at or below the highest stalled index.
    assign hold[k] = |(bus.stall_req >> k);

    if (k == 0) begin : g_head
      assign bubble[k] = 1'b0;

      // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
      always_comb begin
        next_valid = bus.in_valid;
        next_data  = bus.in_valid ? bus.in_data : '0;
      end
    end else begin : g_body
      // Only the register directly above the highest stall takes the bubble.
      assign bubble[k] = bus.stall_req[k-1] & ~hold[k];

      always_comb begin
        next_valid = valid_q[k-1];
        next_data  = data_q[k-1];
      end
    end

    // NOTE: data is reset too, not just valid, so a cleared stage always reads as a NOP.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        // NOTE: state is updated with non-blocking assignments so all stages shift in lockstep.
        valid_r <= 1'b0;
        data_r  <= '0;
      end else if ((FLUSHABLE && bus.flush) || bubble[k]) begin
        valid_r <= 1'b0;
        data_r  <= '0;
      end else if (!hold[k]) begin
        valid_r <= next_valid;
        data_r  <= next_data;
      end
    end

    assign valid_q[k]                 = valid_r;
    assign data_q[k]                  = data_r;
    assign bus.stage_data[k*DW +: DW] = data_r;
  end

  assign bus.stage_valid = valid_q;
  assign bus.out_valid   = valid_q[STAGES-1];
  assign bus.out_data    = data_q[STAGES-1];

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;
  logic [31:0] retire_cnt_q;
  logic        retire_evt;

  // The last stage retires whenever it is valid and not held for write-back.
  assign retire_evt = valid_q[STAGES-1] & ~bus.stall_req[STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      if (|bus.stall_req && stall_cnt_q != '1) stall_cnt_q  <= stall_cnt_q + 32'd1;
      if (bus.flush && flush_cnt_q != '1)      flush_cnt_q  <= flush_cnt_q + 32'd1;
      if (retire_evt && retire_cnt_q != '1)    retire_cnt_q <= retire_cnt_q + 32'd1;
    end
  end

  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.flush_cnt  = flush_cnt_q;
  assign bus.retire_cnt = retire_cnt_q;
`else
  assign bus.stall_cnt  = '0;
  assign bus.flush_cnt  = '0;
  assign bus.retire_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: directed vector table for the hazard scenarios,
// mid-stream asynchronous reset, then randomized traffic against a reference model.
module tb_pipe_stage_chain;

  localparam int DW     = 32;
  localparam int STAGES = 4;
  localparam int FD     = 2;
  localparam int W      = STAGES * DW;
`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk;
  logic rst;

  pipe_stage_chain_if #(.DW(DW), .STAGES(STAGES)) bus ();

  pipe_stage_chain #(.DW(DW), .STAGES(STAGES), .FLUSH_DEPTH(FD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: one valid bit and payload per register.
  bit          m_v [STAGES];
  logic [DW-1:0] m_d [STAGES];
  logic [31:0] m_stall, m_flush, m_retire;

  typedef struct {
    bit       iv;
    bit [3:0] stall;
    bit       flush;
    bit [3:0] exp_sv;
    int       exp_src;   // step whose payload is expected on out_data, -1 for zero
  } vec_t;

  vec_t vecs [28];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pay(input int i);
    case (i)
      0:       return 32'h0100_0293;
      1:       return 32'h0050_2023;
      2:       return 32'h0000_2303;
      default: return 32'hC0DE_0000 | DW'(i);
    endcase
  endfunction

  function automatic vec_t v(input bit iv, input bit [3:0] st, input bit fl,
                             input bit [3:0] sv, input int src);
    vec_t r;
    r.iv = iv; r.stall = st; r.flush = fl; r.exp_sv = sv; r.exp_src = src;
    return r;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < STAGES; k++) begin
      m_v[k] = 1'b0;
      m_d[k] = '0;
    end
    m_stall = '0; m_flush = '0; m_retire = '0;
  endtask

  // One clock edge, from the textual rules: find the highest stall, hold below,
  // bubble just above, shift the rest, then let flush override the front.
  task automatic model_step();
    bit            nv [STAGES];
    logic [DW-1:0] nd [STAGES];
    int h;
    h = -1;
    for (int k = 0; k < STAGES; k++) if (bus.stall_req[k]) h = k;
    if (PERF) begin
      if (h >= 0) m_stall = sat_inc(m_stall);
      if (bus.flush) m_flush = sat_inc(m_flush);
      if (m_v[STAGES-1] && !bus.stall_req[STAGES-1]) m_retire = sat_inc(m_retire);
    end
    for (int k = 0; k < STAGES; k++) begin
      if (h >= 0 && k <= h) begin
        nv[k] = m_v[k]; nd[k] = m_d[k];
      end else if (h >= 0 && k == h + 1) begin
        nv[k] = 1'b0; nd[k] = '0;
      end else if (k == 0) begin
        nv[k] = bus.in_valid; nd[k] = bus.in_valid ? bus.in_data : '0;
      end else begin
        nv[k] = m_v[k-1]; nd[k] = m_d[k-1];
      end
      if (bus.flush && k < FD) begin
        nv[k] = 1'b0; nd[k] = '0;
      end
    end
    for (int k = 0; k < STAGES; k++) begin
      m_v[k] = nv[k];
      m_d[k] = nd[k];
    end
  endtask

  task automatic compare_model(input string tag);
    logic [STAGES-1:0] sv;
    logic [W-1:0]      sd;
    for (int k = 0; k < STAGES; k++) begin
      sv[k]          = m_v[k];
      sd[k*DW +: DW] = m_d[k];
    end
    check({tag, " stage_valid"}, W'(bus.stage_valid), W'(sv));
    check({tag, " stage_data"},  bus.stage_data, sd);
    check({tag, " out_valid"},   W'(bus.out_valid), W'(m_v[STAGES-1]));
    check({tag, " out_data"},    W'(bus.out_data), W'(m_d[STAGES-1]));
    check({tag, " stall_cnt"},   W'(bus.stall_cnt), W'(m_stall));
    check({tag, " flush_cnt"},   W'(bus.flush_cnt), W'(m_flush));
    check({tag, " retire_cnt"},  W'(bus.retire_cnt), W'(m_retire));
  endtask

  task automatic drive(input bit iv, input logic [DW-1:0] d, input bit [3:0] st, input bit fl);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.stall_req = st;
    bus.flush     = fl;
  endtask

  task automatic check_ready(input string tag);
    check({tag, " in_ready"}, W'(bus.in_ready), W'(bus.stall_req == '0 && !bus.flush));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    compare_model(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = v(1, 4'b0000, 0, 4'b0001, -1);
    vecs[1]  = v(1, 4'b0000, 0, 4'b0011, -1);
    vecs[2]  = v(1, 4'b0000, 0, 4'b0111, -1);
    vecs[3]  = v(0, 4'b0000, 0, 4'b1110,  0);
    vecs[4]  = v(0, 4'b0000, 0, 4'b1100,  1);
    vecs[5]  = v(0, 4'b0000, 0, 4'b1000,  2);
    vecs[6]  = v(0, 4'b0000, 0, 4'b0000, -1);
    vecs[7]  = v(1, 4'b0000, 0, 4'b0001, -1);
    vecs[8]  = v(1, 4'b0000, 0, 4'b0011, -1);
    vecs[9]  = v(1, 4'b0000, 0, 4'b0111, -1);
    vecs[10] = v(1, 4'b0000, 0, 4'b1111,  7);
    vecs[11] = v(1, 4'b0010, 0, 4'b1011,  8);   // load-use stall
    vecs[12] = v(1, 4'b0000, 0, 4'b0111, -1);
    vecs[13] = v(1, 4'b0000, 0, 4'b1111,  9);
    vecs[14] = v(1, 4'b0000, 1, 4'b1100, 10);   // branch flush
    vecs[15] = v(1, 4'b0000, 0, 4'b1001, 12);
    vecs[16] = v(1, 4'b0000, 0, 4'b0011, -1);
    vecs[17] = v(1, 4'b0000, 0, 4'b0111, -1);
    vecs[18] = v(1, 4'b0000, 0, 4'b1111, 15);
    vecs[19] = v(1, 4'b0100, 1, 4'b0100, -1);   // flush beats stall
    vecs[20] = v(1, 4'b0000, 0, 4'b1001, 16);
    vecs[21] = v(1, 4'b0000, 0, 4'b0011, -1);
    vecs[22] = v(1, 4'b0000, 0, 4'b0111, -1);
    vecs[23] = v(1, 4'b0000, 0, 4'b1111, 20);
    vecs[24] = v(1, 4'b1000, 0, 4'b1111, 20);   // last-stage stall x3
    vecs[25] = v(1, 4'b1000, 0, 4'b1111, 20);
    vecs[26] = v(1, 4'b1000, 0, 4'b1111, 20);
    vecs[27] = v(0, 4'b0000, 0, 4'b1110, 21);

    rst = 1'b0;
    drive(0, '0, '0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_model("reset");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 28; i++) begin
      logic [DW-1:0] exp_out;
      drive(vecs[i].iv, pay(i), vecs[i].stall, vecs[i].flush);
      #1;
      check_ready($sformatf("vec%0d", i));
      cycle($sformatf("vec%0d model", i));
      exp_out = (vecs[i].exp_src < 0) ? '0 : pay(vecs[i].exp_src);
      check($sformatf("vec%0d table stage_valid", i), W'(bus.stage_valid), W'(vecs[i].exp_sv));
      check($sformatf("vec%0d table out_data", i), W'(bus.out_data), W'(exp_out));
      if (i == 6)  check("stream retire_cnt", W'(bus.retire_cnt), W'(PERF ? 3 : 0));
      if (i == 11) begin
        check("load_use reg0 held", W'(bus.stage_data[0 +: DW]), W'(pay(10)));
        check("load_use stall_cnt", W'(bus.stall_cnt), W'(PERF ? 1 : 0));
      end
      if (i == 14) begin
        check("flush front data", W'(bus.stage_data[0 +: 2*DW]), '0);
        check("flush flush_cnt", W'(bus.flush_cnt), W'(PERF ? 1 : 0));
      end
      if (i == 26) check("last_stall retire_cnt", W'(bus.retire_cnt), W'(PERF ? 10 : 0));
    end

    // Asynchronous reset pulse between edges, mid-stream.
    for (int i = 0; i < 5; i++) begin
      drive(1, $urandom, '0, 0);
      cycle("pre_reset");
    end
    drive(1, $urandom, '0, 0);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    compare_model("async_reset");
    check("reset in_ready ungated", W'(bus.in_ready), W'(1));
    #1;
    rst = 1'b1;
    cycle("post_reset");

    for (int i = 0; i < 400; i++) begin
      bit [3:0] st;
      bit       fl;
      st = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      fl = ($urandom_range(0, 7) == 0);
      drive(bit'($urandom), $urandom, st, fl);
      #1;
      check_ready("rand");
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_chain.md
# pipe_stage_chain

Parametrised pipeline register chain replacing the four hand-instantiated stage registers between IF/ID, ID/EX, EX/MEM and MEM/WB in the CPU core. It carries a DW-bit payload through STAGES registers with per-stage valid bits, stall-and-bubble insertion at any depth, and a front-end flush of configurable depth for taken branches and jumps. Hazard and branch logic drive it; the register file and write-back mux consume its last stage.

## Interface
- DW, 32: payload width per stage in bits; must be 1 or more.
- STAGES, 4: number of pipeline registers; must be 2 or more. Register 0 is IF/ID and register STAGES-1 is MEM/WB.
- FLUSH_DEPTH, 2: registers 0..FLUSH_DEPTH-1 are cleared by `flush`; range 0..STAGES.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch stage presents a payload.
- in_data  in  DW  payload to load into register 0.
- in_ready  out  1  register 0 accepts this cycle.
- stall_req  in  STAGES  bit k requests that register k hold.
- flush  in  1  discards the wrong path in registers 0..FLUSH_DEPTH-1.
- stage_valid  out  STAGES  valid bit of each register.
- stage_data  out  STAGES*DW  payload of register k, in bits [k*DW +: DW].
- out_valid  out  1  equal to stage_valid[STAGES-1].
- out_data  out  DW  payload of register STAGES-1.
- stall_cnt  out  32  performance counter for stall cycles.
- flush_cnt  out  32  performance counter for flush cycles.
- retire_cnt  out  32  performance counter for retired payloads.

## Operation
- h is the highest index k with stall_req[k]=1. h is undefined when stall_req is all zero.
- With no stall, every register k≥1 loads register k-1 (valid and data). Register 0 loads {in_valid, in_data} when in_ready is 1.
- With stall index h:
  - Registers 0..h hold their contents.
  - Register h+1, if it exists, loads a bubble: valid=0, data=0.
  - Registers above h+1 shift normally.
- Flush: registers 0..FLUSH_DEPTH-1 load valid=0 and data=0. This applies whether or not those registers are held or bubbled, so flush beats stall. Registers at FLUSH_DEPTH and above follow the stall and shift rules unchanged.
- in_ready = ~|stall_req & ~flush. The ready signal is combinational and is not gated by reset. A payload offered during a flush is not accepted.
- Any register whose valid is 0 always holds data 0. Downstream control fields therefore decode as a NOP.
- Stall on the last register (h=STAGES-1) holds the whole chain. No bubble is produced, and out_valid and out_data stay stable.
- No ready input exists on the output side. Write-back always consumes the last stage.

## Timing
- Reset (rst=0, asynchronous) sets:
  - all stage_valid to 0 and all stage_data to 0;
  - out_valid=0 and out_data=0;
  - all counters to 0.
- Reset takes effect immediately, even mid-stall or mid-flush. The first capture happens on the first rising edge after rst returns to 1.
- Latency: a payload accepted at edge n appears on out_valid at edge n+STAGES-1, counting register 0 as edge n, provided no stall occurs. Each stall cycle covering its position adds 1 cycle.
- stall_req and flush are sampled on the rising edge. Their effect is visible on the outputs right after that edge.
- Throughput: 1 payload per cycle when stall_req=0 and flush=0.

## Configuration
- PIPE_PERF_CNT_EN defined:
  - stall_cnt increments each cycle in which |stall_req is 1.
  - flush_cnt increments each cycle in which flush is 1.
  - retire_cnt increments each cycle in which out_valid=1 and stall_req[STAGES-1]=0.
  - All three counters saturate at 32'hFFFF_FFFF. Simultaneous events increment each counter independently.
- PIPE_PERF_CNT_EN undefined: the three counter ports remain present and are tied to 0, and no counter flops are built.

## Test plan
All scenarios use STAGES=4, DW=32, FLUSH_DEPTH=2.
- Streaming: inject 32'h0100_0293, 32'h0050_2023, 32'h0000_2303 on consecutive cycles with no stall. Required: out_data shows them on edges 4, 5 and 6 after the first accept, and retire_cnt=3.
- Load-use stall: assert stall_req=4'b0010 for 1 cycle. Required:
  - registers 0 and 1 hold, in_ready=0;
  - register 2 becomes valid=0, data=0;
  - register 3 receives the old register 2;
  - stall_cnt increments by 1.
- Branch flush: assert flush for 1 cycle with all registers valid. Required: stage_valid=4'b1100, registers 0 and 1 have data 0, and flush_cnt=1.
- Flush with stall: assert flush=1 and stall_req=4'b0100 together. Required:
  - registers 0 and 1 are cleared (flush beats hold);
  - register 2 holds;
  - register 3 becomes a bubble.
- Last-stage stall: assert stall_req[3]=1 for 3 cycles. Required: every register is unchanged, and retire_cnt does not increment during those cycles.
- Reset: drive rst low mid-stream for less than one cycle, between edges. Required: all valid and data go to 0 immediately, and the counters go to 0.
